// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizing helpers and default types for the multi-ported register bank
package regbank_pkg;
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction
  localparam int NUMREGS_DEF = 32;
  localparam int DATAWIDTH_DEF = 32;
  localparam int AW_DEF = $clog2(NUMREGS_DEF);
  typedef logic [AW_DEF-1:0] rf_addr_t;
  typedef logic [DATAWIDTH_DEF-1:0] rf_data_t;
endpackage

// File: rtl/regbank_fwd_sel.sv
// regbank_fwd_sel: per-read-port write-to-read bypass, highest-index write port wins
module regbank_fwd_sel #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int NUM_WR = 1
) (
  input  logic [AW-1:0]        raddr,
  input  logic [NUM_WR-1:0]    we,
  input  logic [NUM_WR*AW-1:0] waddr,
  input  logic [NUM_WR*DW-1:0] wdata,
  input  logic [DW-1:0]        bank_word,
  output logic [DW-1:0]        data,
  output logic                 hit
);
  always_comb begin
    data = bank_word;
    hit = 1'b0;
    for (int w = 0; w < NUM_WR; w++)
      if (we[w] && waddr[w*AW +: AW] == raddr) begin
        data = wdata[w*DW +: DW];
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/regbank_mp.sv
// regbank_mp: multi-ported register bank with registered bypassed reads and pending scoreboard
// REGBANK_ZERO_REG_EN makes register 0 hardwired zero (writes, bypass and reserves to it ignored).
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int NUMREGS = NUMREGS_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW = addr_w(NUMREGS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_RD-1:0]           re_i,
  input  logic [NUM_RD*AW-1:0]        raddr_i,
  output logic [NUM_RD*DATAWIDTH-1:0] rdata_o,
  output logic [NUM_RD-1:0]           rbusy_o,
  input  logic [NUM_WR-1:0]           we_i,
  input  logic [NUM_WR*AW-1:0]        waddr_i,
  input  logic [NUM_WR*DATAWIDTH-1:0] wdata_i,
  input  logic                        rsv_i,
  input  logic [AW-1:0]               rsv_addr_i,
  output logic [NUMREGS-1:0]          pending_o
);
  logic [DATAWIDTH-1:0] bank_q [NUMREGS];
  logic [NUMREGS-1:0]   pending_q;
  logic [NUM_WR-1:0]    we_eff;
  logic                 rsv_eff;
  logic [DATAWIDTH-1:0] sel_data [NUM_RD];
  logic [NUM_RD-1:0]    hit;
`ifdef REGBANK_ZERO_REG_EN
  // Masking writes to r0 here also suppresses bypass to r0 in every selector.
  always_comb
    for (int w = 0; w < NUM_WR; w++) we_eff[w] = we_i[w] && |waddr_i[w*AW +: AW];
  assign rsv_eff = rsv_i && |rsv_addr_i;
`else
  assign we_eff = we_i;
  assign rsv_eff = rsv_i;
`endif
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regbank_fwd_sel #(.AW(AW), .DW(DATAWIDTH), .NUM_WR(NUM_WR)) u_sel (
      .raddr(raddr_i[p*AW +: AW]),
      .we(we_eff),
      .waddr(waddr_i),
      .wdata(wdata_i),
      .bank_word(bank_q[raddr_i[p*AW +: AW]]),
      .data(sel_data[p]),
      .hit(hit[p])
    );
  end
  // Ascending port order lets the last NBA (highest index) win; reserve follows the clears.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int r = 0; r < NUMREGS; r++) bank_q[r] <= '0;
      pending_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (we_eff[w]) begin
          bank_q[waddr_i[w*AW +: AW]] <= wdata_i[w*DATAWIDTH +: DATAWIDTH];
          pending_q[waddr_i[w*AW +: AW]] <= 1'b0;
        end
      if (rsv_eff) pending_q[rsv_addr_i] <= 1'b1;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rdata_o <= '0;
      rbusy_o <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rdata_o[p*DATAWIDTH +: DATAWIDTH] <= re_i[p] ? sel_data[p] : '0;
        rbusy_o[p] <= re_i[p] & pending_q[raddr_i[p*AW +: AW]] & ~hit[p];
      end
    end
  assign pending_o = pending_q;
endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: directed self-checking bench for regbank_mp (2 read ports, 2 write ports)
module tb_regbank_mp;
`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [1:0]  re_i;
  logic [9:0]  raddr_i;
  logic [63:0] rdata_o;
  logic [1:0]  rbusy_o;
  logic [1:0]  we_i;
  logic [9:0]  waddr_i;
  logic [63:0] wdata_i;
  logic        rsv_i;
  logic [4:0]  rsv_addr_i;
  logic [31:0] pending_o;
  int checks = 0;
  int errors = 0;

  regbank_mp #(.NUMREGS(32), .DATAWIDTH(32), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rbusy_o(rbusy_o), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .rsv_i(rsv_i),
    .rsv_addr_i(rsv_addr_i), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd(input int p);
    return rdata_o[p*32 +: 32];
  endfunction

  task automatic idle();
    re_i = '0; raddr_i = '0; we_i = '0; waddr_i = '0; wdata_i = '0; rsv_i = 1'b0; rsv_addr_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (rdata_o !== 64'h0 || rbusy_o !== 2'b0 || pending_o !== 32'h0) begin
      errors++; $display("FAIL reset_state rdata=%h rbusy=%b pending=%h exp 0", rdata_o, rbusy_o, pending_o);
    end
    #10 rst_ni = 1'b1;
    for (int r = 0; r < 32; r++) begin
      re_i = 2'b11; raddr_i = {r[4:0], r[4:0]};
      cyc();
      checks++; if (rdata_o !== 64'h0 || rbusy_o !== 2'b0 || pending_o !== 32'h0) begin
        errors++; $display("FAIL reset_read r%0d rdata=%h rbusy=%b pending=%h exp 0", r, rdata_o, rbusy_o, pending_o);
      end
    end
    idle(); we_i = 2'b01; waddr_i = {5'd0, 5'd4}; wdata_i = {32'h0, 32'h1234}; rsv_i = 1'b1; rsv_addr_i = 5'd6;
    cyc();
    idle(); re_i = 2'b01; raddr_i = {5'd0, 5'd4};
    cyc();
    checks++; if (rd(0) !== 32'h1234 || pending_o !== 32'h40) begin
      errors++; $display("FAIL pre_reset rdata0=%h pending=%h exp 1234 00000040", rd(0), pending_o);
    end
    we_i = 2'b01; waddr_i = {5'd0, 5'd3}; wdata_i = {32'h0, 32'h5555};
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++; if (rdata_o !== 64'h0 || pending_o !== 32'h0) begin
      errors++; $display("FAIL async_reset rdata=%h pending=%h exp 0", rdata_o, pending_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(); re_i = 2'b11; raddr_i = {5'd4, 5'd3};
    cyc();
    checks++; if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
      errors++; $display("FAIL write_lost r3=%h r4=%h exp 0 0", rd(0), rd(1));
    end
  endtask

  task automatic test_write_read();
    idle(); we_i = 2'b01; waddr_i = {5'd0, 5'd5}; wdata_i = {32'h0, 32'hDEADBEEF};
    cyc();
    idle(); re_i = 2'b01; raddr_i = {5'd0, 5'd5};
    checks++; if (rd(0) !== 32'h0) begin
      errors++; $display("FAIL read_latency rdata0=%h exp 0", rd(0));
    end
    cyc();
    checks++; if (rd(0) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read rdata0=%h exp deadbeef", rd(0));
    end
    idle(); raddr_i = {5'd5, 5'd5};
    cyc();
    checks++; if (rdata_o !== 64'h0 || rbusy_o !== 2'b0) begin
      errors++; $display("FAIL re_low rdata=%h rbusy=%b exp 0", rdata_o, rbusy_o);
    end
  endtask

  task automatic test_multi_write();
    idle(); we_i = 2'b11; waddr_i = {5'd7, 5'd7}; wdata_i = {32'h22, 32'h11};
    re_i = 2'b10; raddr_i = {5'd7, 5'd0};
    cyc();
    checks++; if (rd(1) !== 32'h22 || rbusy_o !== 2'b00) begin
      errors++; $display("FAIL multi_bypass rdata1=%h rbusy=%b exp 22 00", rd(1), rbusy_o);
    end
    idle(); re_i = 2'b11; raddr_i = {5'd7, 5'd7};
    cyc();
    checks++; if (rd(0) !== 32'h22 || rd(1) !== 32'h22) begin
      errors++; $display("FAIL multi_bank rdata0=%h rdata1=%h exp 22 22", rd(0), rd(1));
    end
  endtask

  task automatic test_pending();
    idle(); rsv_i = 1'b1; rsv_addr_i = 5'd9;
    cyc();
    checks++; if (pending_o !== 32'h200) begin
      errors++; $display("FAIL rsv_set pending=%h exp 00000200", pending_o);
    end
    idle(); re_i = 2'b11; raddr_i = {5'd8, 5'd9};
    cyc();
    checks++; if (rbusy_o !== 2'b01 || rd(0) !== 32'h0) begin
      errors++; $display("FAIL busy_read rbusy=%b rdata0=%h exp 01 0", rbusy_o, rd(0));
    end
    idle(); we_i = 2'b10; waddr_i = {5'd9, 5'd0}; wdata_i = {32'h5, 32'h0}; re_i = 2'b01; raddr_i = {5'd0, 5'd9};
    cyc();
    checks++; if (rd(0) !== 32'h5 || rbusy_o !== 2'b00 || pending_o !== 32'h0) begin
      errors++; $display("FAIL writeback rdata0=%h rbusy=%b pending=%h exp 5 00 0", rd(0), rbusy_o, pending_o);
    end
    idle(); rsv_i = 1'b1; rsv_addr_i = 5'd9; we_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'h0, 32'h6};
    cyc();
    checks++; if (pending_o !== 32'h200) begin
      errors++; $display("FAIL rsv_and_write pending=%h exp 00000200", pending_o);
    end
    idle(); re_i = 2'b10; raddr_i = {5'd9, 5'd0};
    cyc();
    checks++; if (rd(1) !== 32'h6 || rbusy_o !== 2'b10) begin
      errors++; $display("FAIL rsv_write_read rdata1=%h rbusy=%b exp 6 10", rd(1), rbusy_o);
    end
    idle(); we_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'h0, 32'h6};
    cyc();
  endtask

  task automatic test_zero_reg();
    idle(); we_i = 2'b01; waddr_i = {5'd0, 5'd0}; wdata_i = {32'h0, 32'hFFFF}; re_i = 2'b10; raddr_i = {5'd0, 5'd0};
    cyc();
    checks++; if (rd(1) !== (ZR ? 32'h0 : 32'hFFFF)) begin
      errors++; $display("FAIL r0_bypass rdata1=%h exp %h", rd(1), ZR ? 32'h0 : 32'hFFFF);
    end
    idle(); rsv_i = 1'b1; rsv_addr_i = 5'd0;
    cyc();
    checks++; if (pending_o[0] !== !ZR) begin
      errors++; $display("FAIL r0_pending pending0=%b exp %b", pending_o[0], !ZR);
    end
    idle(); re_i = 2'b11; raddr_i = {5'd0, 5'd0};
    cyc();
    checks++; if (rd(0) !== (ZR ? 32'h0 : 32'hFFFF) || rd(1) !== rd(0) || rbusy_o !== (ZR ? 2'b00 : 2'b11)) begin
      errors++; $display("FAIL r0_read rdata=%h rbusy=%b exp %h x2 busy %b", rdata_o, rbusy_o, ZR ? 32'h0 : 32'hFFFF, ZR ? 2'b00 : 2'b11);
    end
    idle(); we_i = 2'b01; waddr_i = '0; wdata_i = '0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    idle();
    for (int i = 0; i < 4; i++) begin
      we_i = 2'b01; waddr_i = {5'd0, 5'(10 + i)}; wdata_i = {32'h0, 32'hA000 + i};
      re_i = 2'b11; raddr_i = {5'(10 + i), 5'(9 + i)};
      cyc();
      exp_d = (i == 0) ? 32'h6 : 32'hA000 + i - 1;
      checks++; if (rd(0) !== exp_d || rd(1) !== 32'hA000 + i) begin
        errors++; $display("FAIL b2b_%0d rdata0=%h rdata1=%h exp %h %h", i, rd(0), rd(1), exp_d, 32'hA000 + i);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_multi_write();
    test_pending();
    test_zero_reg();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
